// File: rtl/led_blink_sched.sv
`default_nettype none
// led_blink_sched: shares one LED among four requesters, granting each a slot of SLOT_BLINKS blinks.
// Define LED_SCHED_RR_EN for round-robin arbitration; otherwise the lowest request index wins.
module led_blink_sched #(
   parameter int DIV_W       = 32,
   parameter int DEFAULT_DIV = 5000,
   parameter int SLOT_BLINKS = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_sel,
   input  logic [DIV_W-1:0] cfg_period,
   output logic [3:0]       grant,
   output logic [3:0]       done,
   output logic             busy,
   output logic             led
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [8:0] LAST_TOGGLE = 9'(2 * SLOT_BLINKS);

   state_t           state_q, state_d;
   logic [3:0]       grant_q, grant_d;
   logic [3:0]       done_q, done_d;
   logic             led_q, led_d;
   logic [1:0]       owner_q, owner_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [8:0]       tog_q, tog_d;
   logic [DIV_W-1:0] period_q [4];
   logic             win_vld;
   logic [1:0]       win_idx;

`ifdef LED_SCHED_RR_EN
   logic [1:0] rr_ptr_q;

   function automatic logic [2:0] pick_rr(input logic [3:0] r, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      {win_vld, win_idx} = pick_rr(req, rr_ptr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= 2'd0;
      end else if (state_q == S_IDLE && win_vld) begin
         rr_ptr_q <= win_idx;
      end
   end
`else
   always_comb begin
      win_vld = |req;
      win_idx = 2'd0;
      if (req[0])      win_idx = 2'd0;
      else if (req[1]) win_idx = 2'd1;
      else if (req[2]) win_idx = 2'd2;
      else if (req[3]) win_idx = 2'd3;
   end
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = 4'b0000;
      led_d   = led_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      tog_d   = tog_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d = S_RUN;
               owner_d = win_idx;
               grant_d = 4'b0001 << win_idx;
               cnt_d   = '0;
               tog_d   = '0;
               led_d   = 1'b1;
            end
         end
         S_RUN: begin
            // Losing the request wins over a completion due in the same cycle.
            if (!req[owner_q]) begin
               state_d = S_IDLE;
               grant_d = 4'b0000;
               led_d   = 1'b0;
               cnt_d   = '0;
               tog_d   = '0;
            end else if (cnt_q >= period_q[owner_q]) begin
               cnt_d = '0;
               if (tog_q + 9'd1 == LAST_TOGGLE) begin
                  state_d = S_IDLE;
                  done_d  = grant_q;
                  grant_d = 4'b0000;
                  led_d   = 1'b0;
                  tog_d   = '0;
               end else begin
                  led_d = ~led_q;
                  tog_d = tog_q + 9'd1;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= 4'b0000;
         done_q  <= 4'b0000;
         led_q   <= 1'b0;
         owner_q <= 2'd0;
         cnt_q   <= '0;
         tog_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         led_q   <= led_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         tog_q   <= tog_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) period_q[i] <= DIV_W'(DEFAULT_DIV);
      end else if (cfg_we) begin
         period_q[cfg_sel] <= cfg_period;
      end
   end

   assign grant = grant_q;
   assign done  = done_q;
   assign led   = led_q;
   assign busy  = (state_q == S_RUN);

endmodule
`default_nettype wire
